// File: rtl/alu_share_resp.sv
// Shared ALU responder: one adder/subtractor + unsigned comparator, arbitrated
// between the main execute datapath and mul/div. Mul/div always wins; an
// ownership FSM adds a one-cycle hand-back bubble and flags overlong ownership.
// Optional macro ALU_RES_REG_EN: register both result paths (1-cycle latency).
module alu_share_resp #(
  parameter int XLEN    = 32,
  parameter int OWN_MAX = 34,
  parameter int CNT_W   = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dp_alu_req,
  input  logic [XLEN-1:0] dp_alu_op1,
  input  logic [XLEN-1:0] dp_alu_op2,
  input  logic            dp_alu_sub,
  output logic            dp_alu_grant,
  output logic [XLEN-1:0] dp_alu_res,
  output logic            dp_alu_ltu,
  output logic            alu_stall,
  input  logic            muldiv_req_alu,
  input  logic [XLEN-1:0] muldiv_req_alu_op1,
  input  logic [XLEN-1:0] muldiv_req_alu_op2,
  input  logic            muldiv_req_alu_ltu,
  output logic [XLEN-1:0] muldiv_req_alu_res,
  output logic            muldiv_req_alu_cmp_res,
  output logic            own_timeout
);

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            sub;
  } alu_req_t;

  typedef enum logic [1:0] {IDLE = 2'd0, MD_OWN = 2'd1, MD_REL = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [CNT_W-1:0] own_cnt, own_cnt_nxt;
  logic            timeout_set;
  alu_req_t        sel;
  logic [XLEN-1:0] sum;
  logic            lt;
  logic            dp_srv, md_srv;
  logic [XLEN-1:0] dp_res_c, md_res_c;
  logic            dp_ltu_c, md_cmp_c;

  // Operand mux into the single adder; mul/div operands take precedence.
  always_comb begin
    if (muldiv_req_alu) begin
      sel.op1 = muldiv_req_alu_op1;
      sel.op2 = muldiv_req_alu_op2;
      sel.sub = muldiv_req_alu_ltu;
    end else begin
      sel.op1 = dp_alu_op1;
      sel.op2 = dp_alu_op2;
      sel.sub = dp_alu_sub;
    end
    sum = sel.op1 + (sel.sub ? ~sel.op2 : sel.op2) + {{(XLEN-1){1'b0}}, sel.sub};
    lt  = sel.op1 < sel.op2;
  end

  // Ownership state, occupancy counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      own_cnt     <= '0;
      own_timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      own_cnt <= own_cnt_nxt;
      if (timeout_set) own_timeout <= 1'b1;
    end
  end

  // Next-state: MD_REL is a single bubble before the datapath gets the ALU back.
  always_comb begin
    state_nxt   = state;
    own_cnt_nxt = own_cnt;
    timeout_set = 1'b0;
    case (state)
      IDLE: if (muldiv_req_alu) begin
        state_nxt   = MD_OWN;
        own_cnt_nxt = CNT_W'(1);
      end
      MD_OWN: if (muldiv_req_alu) begin
        if (own_cnt != '1) own_cnt_nxt = own_cnt + 1'b1;
        timeout_set = (own_cnt == CNT_W'(OWN_MAX));
      end else begin
        state_nxt   = MD_REL;
        own_cnt_nxt = '0;
      end
      MD_REL: if (muldiv_req_alu) begin
        state_nxt   = MD_OWN;
        own_cnt_nxt = CNT_W'(1);
      end else begin
        state_nxt   = IDLE;
        own_cnt_nxt = '0;
      end
      default: begin
        state_nxt   = IDLE;
        own_cnt_nxt = '0;
      end
    endcase
  end

  // Grant/stall and per-requester results; everything forced to 0 in reset.
  always_comb begin
    md_srv       = rst_n & muldiv_req_alu;
    dp_srv       = rst_n & dp_alu_req & (state == IDLE) & ~muldiv_req_alu;
    dp_alu_grant = dp_srv;
    alu_stall    = rst_n & dp_alu_req & ~dp_srv;
    md_res_c     = md_srv ? sum : '0;
    md_cmp_c     = md_srv & lt;
    dp_res_c     = dp_srv ? sum : '0;
    dp_ltu_c     = dp_srv & lt;
  end

`ifdef ALU_RES_REG_EN
  // Registered results: a cycle with no service loads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_alu_res             <= '0;
      dp_alu_ltu             <= 1'b0;
      muldiv_req_alu_res     <= '0;
      muldiv_req_alu_cmp_res <= 1'b0;
    end else begin
      dp_alu_res             <= dp_res_c;
      dp_alu_ltu             <= dp_ltu_c;
      muldiv_req_alu_res     <= md_res_c;
      muldiv_req_alu_cmp_res <= md_cmp_c;
    end
  end
`else
  assign dp_alu_res             = dp_res_c;
  assign dp_alu_ltu             = dp_ltu_c;
  assign muldiv_req_alu_res     = md_res_c;
  assign muldiv_req_alu_cmp_res = md_cmp_c;
`endif

endmodule

// File: tb/tb_alu_share_resp.sv
// Scoreboard bench for alu_share_resp: stimulus pushes expected results,
// a negedge monitor pops them whenever a requester is served.
module tb_alu_share_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dp_alu_req, dp_alu_sub, dp_alu_grant, dp_alu_ltu, alu_stall;
  logic [31:0] dp_alu_op1, dp_alu_op2, dp_alu_res;
  logic        muldiv_req_alu, muldiv_req_alu_ltu, muldiv_req_alu_cmp_res, own_timeout;
  logic [31:0] muldiv_req_alu_op1, muldiv_req_alu_op2, muldiv_req_alu_res;

  alu_share_resp dut (
    .clk(clk), .rst_n(rst_n),
    .dp_alu_req(dp_alu_req), .dp_alu_op1(dp_alu_op1), .dp_alu_op2(dp_alu_op2),
    .dp_alu_sub(dp_alu_sub), .dp_alu_grant(dp_alu_grant), .dp_alu_res(dp_alu_res),
    .dp_alu_ltu(dp_alu_ltu), .alu_stall(alu_stall),
    .muldiv_req_alu(muldiv_req_alu), .muldiv_req_alu_op1(muldiv_req_alu_op1),
    .muldiv_req_alu_op2(muldiv_req_alu_op2), .muldiv_req_alu_ltu(muldiv_req_alu_ltu),
    .muldiv_req_alu_res(muldiv_req_alu_res), .muldiv_req_alu_cmp_res(muldiv_req_alu_cmp_res),
    .own_timeout(own_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        cmp;
  } exp_t;

  exp_t dp_q[$], md_q[$];
  exp_t e;
  int   n_tests = 0, n_fail = 0;
  logic dp_s, md_s;
  logic dp_pend = 1'b0, md_pend = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic set_in(input logic dr, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic mr, input logic [31:0] ma, input logic [31:0] mb, input logic ml);
    dp_alu_req = dr; dp_alu_op1 = a; dp_alu_op2 = b; dp_alu_sub = s;
    muldiv_req_alu = mr; muldiv_req_alu_op1 = ma; muldiv_req_alu_op2 = mb; muldiv_req_alu_ltu = ml;
  endtask

  task automatic push_dp(input logic [31:0] r, input logic c);
    exp_t x; x.res = r; x.cmp = c; dp_q.push_back(x);
  endtask

  task automatic push_md(input logic [31:0] r, input logic c);
    exp_t x; x.res = r; x.cmp = c; md_q.push_back(x);
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  // Monitor: compare results of served requesters, unserved paths must read 0.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef ALU_RES_REG_EN
      if (dp_pend && dp_q.size() > 0) dp_q.delete(0);
      if (md_pend && md_q.size() > 0) md_q.delete(0);
`endif
      dp_pend = 1'b0;
      md_pend = 1'b0;
    end else begin
`ifdef ALU_RES_REG_EN
      dp_s = dp_pend; md_s = md_pend;
      dp_pend = dp_alu_grant; md_pend = muldiv_req_alu;
`else
      dp_s = dp_alu_grant; md_s = muldiv_req_alu;
`endif
      if (dp_s) begin
        if (dp_q.size() == 0) chk("dp_unexpected_grant", 32'd1, 32'd0);
        else begin
          e = dp_q.pop_front();
          chk("dp_res", dp_alu_res, e.res);
          chk("dp_ltu", {31'd0, dp_alu_ltu}, {31'd0, e.cmp});
        end
      end else begin
        chk("dp_res_unserved", dp_alu_res, 32'd0);
        chk("dp_ltu_unserved", {31'd0, dp_alu_ltu}, 32'd0);
      end
      if (md_s) begin
        if (md_q.size() == 0) chk("md_unexpected_serve", 32'd1, 32'd0);
        else begin
          e = md_q.pop_front();
          chk("md_res", muldiv_req_alu_res, e.res);
          chk("md_cmp", {31'd0, muldiv_req_alu_cmp_res}, {31'd0, e.cmp});
        end
      end else begin
        chk("md_res_unserved", muldiv_req_alu_res, 32'd0);
        chk("md_cmp_unserved", {31'd0, muldiv_req_alu_cmp_res}, 32'd0);
      end
    end
  end

  initial begin
    // T1: reset with every request asserted -> all outputs 0
    set_in(1'b1, 32'd11, 32'd22, 1'b1, 1'b1, 32'd33, 32'd44, 1'b1);
    #12;
    chk("rst_grant", {31'd0, dp_alu_grant}, 32'd0);
    chk("rst_stall", {31'd0, alu_stall}, 32'd0);
    chk("rst_dp_res", dp_alu_res, 32'd0);
    chk("rst_dp_ltu", {31'd0, dp_alu_ltu}, 32'd0);
    chk("rst_md_res", muldiv_req_alu_res, 32'd0);
    chk("rst_md_cmp", {31'd0, muldiv_req_alu_cmp_res}, 32'd0);
    chk("rst_timeout", {31'd0, own_timeout}, 32'd0);
    next_cyc();
    set_in(1'b1, 32'd5, 32'd3, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    push_dp(32'd8, 1'b0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t1_grant", {31'd0, dp_alu_grant}, 32'd1);
    chk("t1_stall", {31'd0, alu_stall}, 32'd0);
    next_cyc();

    // T2: mul/div subtract 3-5 with unsigned compare
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd3, 32'd5, 1'b1);
    push_md(32'hFFFF_FFFE, 1'b1);
    @(negedge clk);
    chk("t2_grant", {31'd0, dp_alu_grant}, 32'd0);
    next_cyc();
    chk("t2_own_cnt", 32'(dut.own_cnt), 32'd1);
    chk("t2_state_own", 32'(dut.state), 32'd1);
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    next_cyc();
    // MD_REL bubble: dp request stalls
    set_in(1'b1, 32'd1, 32'd1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("t2_rel_stall", {31'd0, alu_stall}, 32'd1);
    chk("t2_rel_grant", {31'd0, dp_alu_grant}, 32'd0);
    next_cyc();
    push_dp(32'd2, 1'b0);
    @(negedge clk);
    chk("t2_idle_grant", {31'd0, dp_alu_grant}, 32'd1);
    next_cyc();

    // T3: collision in IDLE -> mul/div wins, dp stalls until back in IDLE
    set_in(1'b1, 32'd4, 32'd10, 1'b1, 1'b1, 32'd7, 32'd9, 1'b0);
    push_md(32'd16, 1'b1);
    @(negedge clk);
    chk("t3_coll_grant", {31'd0, dp_alu_grant}, 32'd0);
    chk("t3_coll_stall", {31'd0, alu_stall}, 32'd1);
    next_cyc();
    set_in(1'b1, 32'd4, 32'd10, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("t3_own_stall", {31'd0, alu_stall}, 32'd1);
    next_cyc();
    @(negedge clk);
    chk("t3_rel_stall", {31'd0, alu_stall}, 32'd1);
    next_cyc();
    push_dp(32'hFFFF_FFFA, 1'b1);
    @(negedge clk);
    chk("t3_grant", {31'd0, dp_alu_grant}, 32'd1);
    chk("t3_nostall", {31'd0, alu_stall}, 32'd0);
    next_cyc();

    // T4: hold mul/div for 35 cycles -> sticky timeout
    for (int i = 0; i < 35; i++) begin
      set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'(i * 3), 32'd50, 1'b0);
      push_md(32'(i * 3 + 50), (i * 3) < 50);
      @(negedge clk);
      if (i == 34) begin
        chk("t4_cnt34", 32'(dut.own_cnt), 32'd34);
        chk("t4_to_before", {31'd0, own_timeout}, 32'd0);
      end
      next_cyc();
    end
    chk("t4_to_rise", {31'd0, own_timeout}, 32'd1);
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    next_cyc();
    // re-request from MD_REL restarts count at 1
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    push_md(32'd0, 1'b0);
    next_cyc();
    chk("t4_rel_cnt1", 32'(dut.own_cnt), 32'd1);
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    next_cyc();
    next_cyc();
    next_cyc();
    chk("t4_to_sticky", {31'd0, own_timeout}, 32'd1);

    // T5: asynchronous reset mid-ownership
    for (int i = 0; i < 10; i++) begin
      set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd100, 32'(i), 1'b1);
      push_md(32'(100 - i), 1'b0);
      next_cyc();
    end
    chk("t5_cnt10", 32'(dut.own_cnt), 32'd10);
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_cnt0", 32'(dut.own_cnt), 32'd0);
    chk("t5_state_idle", 32'(dut.state), 32'd0);
    chk("t5_to_clr", {31'd0, own_timeout}, 32'd0);
    #1 rst_n = 1'b1;
    next_cyc();
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd1, 32'd2, 1'b0);
    push_md(32'd3, 1'b1);
    next_cyc();
    chk("t5_cnt1", 32'(dut.own_cnt), 32'd1);
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    next_cyc();
    next_cyc();

`ifdef ALU_RES_REG_EN
    // T6: registered wrap-around result, previous idle cycle reads 0
    set_in(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    push_dp(32'd0, 1'b0);
    @(negedge clk);
    chk("t6_prev_zero", dp_alu_res, 32'd0);
    chk("t6_grant", {31'd0, dp_alu_grant}, 32'd1);
    next_cyc();
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
`else
    // wrap-around add, combinational
    set_in(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    push_dp(32'd0, 1'b0);
    @(negedge clk);
    chk("wrap_grant", {31'd0, dp_alu_grant}, 32'd1);
    next_cyc();
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
`endif
    next_cyc();
    next_cyc();
    chk("dp_q_drained", 32'(dp_q.size()), 32'd0);
    chk("md_q_drained", 32'(md_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
